life_engine: RTL and testbench
==============================

# life_engine

Parametrised Game of Life compute core with a double-buffered board, a configurable birth/survival rule, optional toroidal wrap, single-step mode and LFSR random seeding. It advances one generation per accepted frame tick. It exposes a combinational cell read port that the VGA pixel pipeline indexes by board coordinate. It sits between the vga_sync-derived frame tick and the pixel colour logic in the top-level TinyTapeout wrapper.

## Interface

Parameters:
- BIT_WIDTH, 3, log2 of board width; W = 2^BIT_WIDTH
- BIT_HEIGHT, 3, log2 of board height; H = 2^BIT_HEIGHT; N = W*H cells, AW = BIT_WIDTH+BIT_HEIGHT

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per frame, already synchronous to clk
- run  in  1  1 = free-run, advance on every accepted frame_tick
- step  in  1  one-cycle pulse; arms a single generation on the next frame_tick
- seed  in  1  one-cycle pulse; refills board from LFSR
- clear  in  1  one-cycle pulse; zeroes board
- wrap  in  1  1 = toroidal neighbourhood, 0 = off-board cells dead
- birth_mask  in  9  bit k = dead cell with k neighbours is born
- survive_mask  in  9  bit k = live cell with k neighbours survives
- rd_x  in  BIT_WIDTH  read column
- rd_y  in  BIT_HEIGHT  read row
- rd_alive  out  1  displayed state of cell {rd_y,rd_x}, combinational
- busy  out  1  state != IDLE
- gen_done  out  1  one-cycle pulse when a generation completes
- gen_count  out  16  generations completed, wraps 0xFFFF->0
- population  out  AW+1  live cells in last completed generation (or after seed/clear)

## Operation

- Storage: cur[N], prev[N]; index = {y,x} (y*W+x). Index counter i is AW bits.
- States: IDLE, SEED, CLEAR, COPY, COMPUTE.
- IDLE priority, highest first: seed -> SEED; clear -> CLEAR; frame_tick with (run or step_armed) -> COPY; otherwise stay. In IDLE, a step pulse sets step_armed.
- SEED: cur[i] <= lfsr[0]. The LFSR advances every cycle. For i = 0..N-1, return to IDLE after i = N-1. population is accumulated.
- CLEAR: cur[i] <= 0 for i = 0..N-1. population <= 0 on exit.
- COPY: prev[i] <= cur[i] for i = 0..N-1. On entry, latch wrap, birth_mask and survive_mask into shadow registers, and clear step_armed.
- COMPUTE: n = count of the 8 neighbours of i in prev, 4 bits, range 0..8.
  - wrap_s=1: coordinates are taken mod W/H.
  - wrap_s=0: off-board neighbours count as 0.
  - Rule: cur[i] <= prev[i] ? survive_s[n] : birth_s[n].
  - Running pop count of new cur values.
  - After i = N-1: population <= count, gen_count++, gen_done=1 for one cycle, -> IDLE.
- Display source:
  - COMPUTE: rd_alive = prev[{rd_y,rd_x}] (stable old generation).
  - All other states: rd_alive = cur[{rd_y,rd_x}].
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, reset 16'hACE1. It advances only in SEED.
- Ignored inputs:
  - frame_tick, seed and clear are ignored while busy.
  - A step pulse while busy is dropped.
  - Changing the mask or wrap inputs mid-generation has no effect until the next COPY.

## Timing

- Reset (async assert): state=IDLE, i=0, cur=prev=0, step_armed=0, gen_count=0, population=0, gen_done=0, busy=0, lfsr=16'hACE1, shadows=0.
- Reset release is treated synchronously; the first transition can occur on the first clk edge after deassertion.
- Generation latency: a tick accepted on edge T gives busy=1 from T+1.
  - COPY occupies N cycles and COMPUTE occupies N cycles.
  - gen_done is high in cycle T+2N; busy falls in the same cycle.
  - gen_count and population are updated on that edge.
- SEED and CLEAR each take N cycles; gen_count is unchanged.
- rd_alive has zero latency: it is combinational from rd_x/rd_y and the current state.
- Reset mid-generation aborts immediately; board contents are lost.

## Test plan

- Reset, clear, then load a blinker at (3,2),(3,3),(3,4) by seed-free backdoor. Apply run=1, wrap=0, B3/S23 (birth=9'h008, survive=9'h00C), one tick -> cells (2,3),(3,3),(4,3) alive; population=3; gen_done exactly 2N=128 cycles after the tick.
- Glider near the bottom-right corner, 4 generations, wrap=1 -> glider reappears shifted (+1,+1) mod 8, population=5 each generation. With wrap=0, the same stimulus -> glider becomes a 2x2 block, population=4.
- run=0 with a step pulse, then 3 ticks -> exactly one generation; gen_count goes 0->1. A tick while busy does not extend or restart.
- Seed pulse from reset -> after 64 cycles, cur matches the reference LFSR sequence from 16'hACE1; population equals its popcount. Then clear -> population=0.
- birth=0, survive=9'h1FF on a random board -> board unchanged after a generation. birth=9'h1FF, survive=0 -> every live cell dies and every dead cell is born.
- Reset asserted at mid-COMPUTE (i=20) -> immediately busy=0, gen_count=0, rd_alive=0 for all coordinates.

Source files
------------

// File: rtl/life_engine.sv
// life_engine: Game of Life compute core with a double-buffered board.
// One generation is produced per accepted frame tick: the current board is
// first copied into the previous buffer (COPY), then every cell is rewritten
// from its previous-generation neighbourhood (COMPUTE). The board can also
// be filled from a 16-bit LFSR (SEED) or zeroed (CLEAR).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   frame_tick            one-cycle frame pulse, synchronous to clk
//   run                   free-run: advance on every accepted frame_tick
//   step                  arms a single generation on the next frame_tick
//   seed / clear          refill board from LFSR / zero the board
//   wrap                  1 = toroidal neighbourhood, 0 = off-board cells dead
//   birth_mask[8:0]       bit k: dead cell with k neighbours is born
//   survive_mask[8:0]     bit k: live cell with k neighbours survives
//   rd_x, rd_y            display read coordinate
//   rd_alive              displayed cell state (combinational)
//   busy                  engine not idle
//   gen_done              one-cycle pulse when a generation completes
//   gen_count[15:0]       generations completed (wrapping)
//   population[AW:0]      live cells after last generation / seed / clear
module life_engine #(
    parameter int unsigned BIT_WIDTH  = 3,
    parameter int unsigned BIT_HEIGHT = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_tick,
    input  logic                          run,
    input  logic                          step,
    input  logic                          seed,
    input  logic                          clear,
    input  logic                          wrap,
    input  logic [8:0]                    birth_mask,
    input  logic [8:0]                    survive_mask,
    input  logic [BIT_WIDTH-1:0]          rd_x,
    input  logic [BIT_HEIGHT-1:0]         rd_y,
    output logic                          rd_alive,
    output logic                          busy,
    output logic                          gen_done,
    output logic [15:0]                   gen_count,
    output logic [BIT_WIDTH+BIT_HEIGHT:0] population
);

    localparam int unsigned AW = BIT_WIDTH + BIT_HEIGHT;
    localparam int unsigned N  = 1 << AW;
    localparam int unsigned PW = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_CLEAR,
        ST_COPY,
        ST_COMPUTE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [AW-1:0]         r_idx;
    logic [N-1:0]          r_cur;
    logic [N-1:0]          r_prev;
    logic                  r_step_armed;
    logic                  r_wrap_s;
    logic [8:0]            r_birth_s;
    logic [8:0]            r_survive_s;
    logic [15:0]           r_lfsr;
    logic [15:0]           r_gen_count;
    logic [PW-1:0]         r_pop_acc;
    logic [PW-1:0]         r_population;
    logic                  r_gen_done;

    logic                  w_last;
    logic [BIT_WIDTH-1:0]  w_x;
    logic [BIT_HEIGHT-1:0] w_y;
    logic [BIT_WIDTH-1:0]  w_nx;
    logic [BIT_HEIGHT-1:0] w_ny;
    logic                  w_nvalid;
    logic [3:0]            w_ncount;
    logic                  w_new_cell;
    logic                  w_lfsr_fb;

    assign w_last    = (r_idx == '1);
    assign w_x       = r_idx[BIT_WIDTH-1:0];
    assign w_y       = r_idx[AW-1:BIT_WIDTH];
    // Fibonacci taps 16,14,13,11 in right-shift form (bits 0,2,3,5)
    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; IDLE requests are prioritised seed > clear > tick
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (seed) begin
                    w_state_nxt = ST_SEED;
                end else if (clear) begin
                    w_state_nxt = ST_CLEAR;
                end else if (frame_tick && (run || r_step_armed)) begin
                    w_state_nxt = ST_COPY;
                end
            end
            ST_SEED, ST_CLEAR, ST_COMPUTE: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COPY: begin
                if (w_last) begin
                    w_state_nxt = ST_COMPUTE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Neighbour count of cell r_idx in the previous generation.
    // Coordinates wrap naturally at the power-of-two board size; without
    // wrap the neighbours that crossed an edge are masked off.
    always_comb begin
        w_ncount = '0;
        w_nx     = '0;
        w_ny     = '0;
        w_nvalid = 1'b0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (dx != 0 || dy != 0) begin
                    w_nx     = w_x + BIT_WIDTH'(dx);
                    w_ny     = w_y + BIT_HEIGHT'(dy);
                    w_nvalid = r_wrap_s
                        || !((dx < 0 && w_x == '0) || (dx > 0 && w_x == '1)
                          || (dy < 0 && w_y == '0) || (dy > 0 && w_y == '1));
                    w_ncount = w_ncount + 4'(r_prev[{w_ny, w_nx}] & w_nvalid);
                end
            end
        end
    end

    assign w_new_cell = r_prev[r_idx] ? r_survive_s[w_ncount] : r_birth_s[w_ncount];

    // Board, index, LFSR, shadow rules and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_cur        <= '0;
            r_prev       <= '0;
            r_step_armed <= 1'b0;
            r_wrap_s     <= 1'b0;
            r_birth_s    <= '0;
            r_survive_s  <= '0;
            r_lfsr       <= 16'hACE1;
            r_gen_count  <= '0;
            r_pop_acc    <= '0;
            r_population <= '0;
            r_gen_done   <= 1'b0;
        end else begin
            r_gen_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_idx     <= '0;
                    r_pop_acc <= '0;
                    if (step) begin
                        r_step_armed <= 1'b1;
                    end
                    // Rules are frozen for the whole generation
                    if (w_state_nxt == ST_COPY) begin
                        r_step_armed <= 1'b0;
                        r_wrap_s     <= wrap;
                        r_birth_s    <= birth_mask;
                        r_survive_s  <= survive_mask;
                    end
                end
                ST_SEED: begin
                    r_cur[r_idx] <= r_lfsr[0];
                    r_lfsr       <= {w_lfsr_fb, r_lfsr[15:1]};
                    r_idx        <= r_idx + AW'(1);
                    r_pop_acc    <= r_pop_acc + PW'(r_lfsr[0]);
                    if (w_last) begin
                        r_population <= r_pop_acc + PW'(r_lfsr[0]);
                    end
                end
                ST_CLEAR: begin
                    r_cur[r_idx] <= 1'b0;
                    r_idx        <= r_idx + AW'(1);
                    if (w_last) begin
                        r_population <= '0;
                    end
                end
                ST_COPY: begin
                    r_prev[r_idx] <= r_cur[r_idx];
                    r_idx         <= r_idx + AW'(1);
                    r_pop_acc     <= '0;
                end
                ST_COMPUTE: begin
                    r_cur[r_idx] <= w_new_cell;
                    r_idx        <= r_idx + AW'(1);
                    r_pop_acc    <= r_pop_acc + PW'(w_new_cell);
                    if (w_last) begin
                        r_population <= r_pop_acc + PW'(w_new_cell);
                        r_gen_count  <= r_gen_count + 16'd1;
                        r_gen_done   <= 1'b1;
                    end
                end
                default: r_idx <= '0;
            endcase
        end
    end

    // Display shows the stable old generation while it is being rewritten
    assign rd_alive   = (r_state == ST_COMPUTE) ? r_prev[{rd_y, rd_x}] : r_cur[{rd_y, rd_x}];
    assign busy       = (r_state != ST_IDLE);
    assign gen_done   = r_gen_done;
    assign gen_count  = r_gen_count;
    assign population = r_population;

endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: scoreboard bench for life_engine on an 8x8 board.
module tb_life_engine;

    localparam int unsigned BW = 3;
    localparam int unsigned BH = 3;
    localparam int N = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       seed = 1'b0;
    logic       clear = 1'b0;
    logic       wrap = 1'b0;
    logic [8:0] birth_mask = '0;
    logic [8:0] survive_mask = '0;
    logic [2:0] rd_x = '0;
    logic [2:0] rd_y = '0;
    logic       rd_alive;
    logic       busy;
    logic       gen_done;
    logic [15:0] gen_count;
    logic [6:0]  population;

    life_engine #(.BIT_WIDTH(BW), .BIT_HEIGHT(BH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .run          (run),
        .step         (step),
        .seed         (seed),
        .clear        (clear),
        .wrap         (wrap),
        .birth_mask   (birth_mask),
        .survive_mask (survive_mask),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_alive     (rd_alive),
        .busy         (busy),
        .gen_done     (gen_done),
        .gen_count    (gen_count),
        .population   (population)
    );

    always #100 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] name;
        bit           is_gen;
        int           pop;
        int           gc;
        logic [63:0]  board;
        bit           chk_board;
        int           exp_cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        tb_snap = 1'b0;
    logic [63:0] load_val = '0;

    task automatic check(input string what, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", what, act, req);
        end
    endtask

    function automatic void push(input logic [127:0] nm, input bit g, input int p, input int c,
                                 input logic [63:0] b, input bit cb, input int ec);
        exp_t e;
        e.name = nm; e.is_gen = g; e.pop = p; e.gc = c;
        e.board = b; e.chk_board = cb; e.exp_cyc = ec;
        sb.push_back(e);
    endfunction

    function automatic logic [63:0] lfsr_board();
        logic [15:0] l = 16'hACE1;
        logic [63:0] b = '0;
        for (int k = 0; k < 64; k++) begin
            b[k] = l[0];
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end
        return b;
    endfunction

    // Monitor: pops an expectation whenever the DUT reports a generation or
    // the stimulus requests a snapshot, then reads the board via rd_x/rd_y.
    initial begin
        exp_t        e;
        logic [63:0] brd;
        forever begin
            @(negedge clk);
            if (gen_done || tb_snap) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: gen_done=%0b snap=%0b at cycle %0d, nothing queued",
                             gen_done, tb_snap, cyc);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("%0s/gen_done", e.name), 64'(gen_done), 64'(e.is_gen));
                    check($sformatf("%0s/busy", e.name), 64'(busy), 64'(0));
                    check($sformatf("%0s/gen_count", e.name), 64'(gen_count), 64'(e.gc));
                    check($sformatf("%0s/population", e.name), 64'(population), 64'(e.pop));
                    if (e.exp_cyc >= 0)
                        check($sformatf("%0s/latency_cycle", e.name), 64'(cyc), 64'(e.exp_cyc));
                    if (e.chk_board) begin
                        brd = '0;
                        for (int k = 0; k < 64; k++) begin
                            rd_y = 3'(k >> 3);
                            rd_x = 3'(k);
                            #1;
                            brd[k] = rd_alive;
                        end
                        check($sformatf("%0s/board", e.name), brd, e.board);
                    end
                end
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        frame_tick = 1'b0; step = 1'b0; seed = 1'b0; clear = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic do_tick(output int acc);
        frame_tick = 1'b1;
        acc = cyc + 1;
        cycles(1);
        frame_tick = 1'b0;
    endtask

    task automatic do_snap();
        tb_snap = 1'b1;
        cycles(1);
        tb_snap = 1'b0;
    endtask

    task automatic load_board(input logic [63:0] b);
        load_val = b;
        force dut.r_cur = load_val;
        cycles(1);
        release dut.r_cur;
        cycles(1);
    endtask

    task automatic wait_idle(input string what);
        int k = 0;
        while ((busy || sb.size() != 0) && k < 2000) begin
            cycles(1);
            k++;
        end
        if (k >= 2000) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s/timeout: busy=%0b pending=%0d after 2000 cycles", what, busy, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int          acc;
        int          pops_w0[4];
        logic [63:0] blink_v, blink_h, glider0, glider4w, block4, rboard;

        blink_v  = 64'h0000_0008_0808_0000;   // (3,2),(3,3),(3,4)
        blink_h  = 64'h0000_0000_1C00_0000;   // (2,3),(3,3),(4,3)
        glider0  = 64'hE080_4000_0000_0000;   // (6,5),(7,6),(5,7),(6,7),(7,7)
        glider4w = 64'h0180_0000_0000_00C1;   // same glider moved (+1,+1) mod 8
        block4   = 64'hC0C0_0000_0000_0000;   // 2x2 block at (6..7,6..7)
        pops_w0  = '{4, 3, 4, 4};

        // Reset state
        do_reset();
        push("reset", 0, 0, 0, '0, 1, -1);
        do_snap();

        // Clear then blinker, one generation, latency 2N
        clear = 1'b1; cycles(1); clear = 1'b0;
        wait_idle("clear0");
        push("clear0", 0, 0, 0, '0, 1, -1);
        do_snap();
        load_board(blink_v);
        run = 1'b1; wrap = 1'b0; birth_mask = 9'h008; survive_mask = 9'h00C;
        do_tick(acc);
        push("blinker", 1, 3, 1, blink_h, 1, acc + 2 * N);
        wait_idle("blinker");
        run = 1'b0;

        // Glider with wrap: 4 generations
        do_reset();
        load_board(glider0);
        run = 1'b1; wrap = 1'b1;
        for (int g = 1; g <= 4; g++) begin
            do_tick(acc);
            push("glider_wrap", 1, 5, g, glider4w, (g == 4), acc + 2 * N);
            wait_idle("glider_wrap");
        end

        // Glider without wrap collapses into a block in the corner
        do_reset();
        load_board(glider0);
        wrap = 1'b0;
        for (int g = 1; g <= 4; g++) begin
            do_tick(acc);
            push("glider_nowrap", 1, pops_w0[g-1], g, block4, (g == 4), acc + 2 * N);
            wait_idle("glider_nowrap");
        end
        run = 1'b0;

        // Single step: unarmed tick ignored, busy ticks ignored, one generation only
        do_reset();
        load_board(blink_v);
        do_tick(acc);
        cycles(3);
        push("unarmed_tick", 0, 0, 0, blink_v, 1, -1);
        do_snap();
        step = 1'b1; cycles(1); step = 1'b0;
        cycles(2);
        do_tick(acc);
        push("step_gen", 1, 3, 1, blink_h, 1, acc + 2 * N);
        cycles(20);
        begin
            int dummy;
            do_tick(dummy);
        end
        wait_idle("step_gen");
        begin
            int dummy2;
            do_tick(dummy2);
        end
        cycles(5);
        push("step_after", 0, 3, 1, blink_h, 1, -1);
        do_snap();

        // LFSR seed from reset, identity and inverting rules, then clear
        do_reset();
        rboard = lfsr_board();
        seed = 1'b1; cycles(1); seed = 1'b0;
        wait_idle("seed");
        push("seed", 0, $countones(rboard), 0, rboard, 1, -1);
        do_snap();
        run = 1'b1; wrap = 1'b1; birth_mask = 9'h000; survive_mask = 9'h1FF;
        do_tick(acc);
        push("rule_identity", 1, $countones(rboard), 1, rboard, 1, acc + 2 * N);
        cycles(10);
        birth_mask = 9'h1FF; survive_mask = 9'h000;   // must not affect this generation
        wait_idle("rule_identity");
        do_tick(acc);
        push("rule_invert", 1, N - $countones(rboard), 2, ~rboard, 1, acc + 2 * N);
        wait_idle("rule_invert");
        run = 1'b0;
        clear = 1'b1; cycles(1); clear = 1'b0;
        wait_idle("clear1");
        push("clear1", 0, 0, 2, '0, 1, -1);
        do_snap();

        // Reset asserted in the middle of COMPUTE (i = 20)
        do_reset();
        load_board(blink_v);
        run = 1'b1; birth_mask = 9'h008; survive_mask = 9'h00C;
        do_tick(acc);
        while (cyc < acc + N + 20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        push("mid_reset", 0, 0, 0, '0, 1, -1);
        do_snap();
        rst_n = 1'b1;
        run = 1'b0;
        cycles(3);

        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL %0s/never_seen: expectation left unconsumed", e.name);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
